// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared reader state type and default RAM geometry
package nn_mem_pkg;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry FIFO (push/din in, pop/dout out, full/empty flags), async active-low reset
module skid_fifo2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic wp, rp, push_ok;
  logic [1:0] cnt;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout = mem[rp];
  assign push_ok = push && (!full || pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop && !empty) rp <= ~rp;
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop && !empty};
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: bursts length words from a 1-cycle-latency RAM (clk, rst_n, start/base_addr/length in; busy/done; mem_a/we/d/q RAM port; out_data/valid/ready/last stream)
module ram_stream_reader
  import nn_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_SIZE  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  rd_state_t state, state_nx;
  logic [ADDR_WIDTH:0] len_q, issued, beats;
  logic inflight, issue, pop, full, empty, last_issue, last_pop, accept;
  logic [1:0] occ;
  assign mem_we = 1'b0;
  assign mem_d = '0;
  assign busy = state != IDLE;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign accept = state == IDLE && start;
  // occupancy after this cycle's pop, so a steady stream can issue every cycle
  assign occ = {1'b0, inflight} + {full, !empty && !full} - {1'b0, pop};
  assign issue = state == RUN && issued != len_q && occ < 2'd2;
  assign last_issue = issue && issued + ONE == len_q;
  assign last_pop = pop && beats + ONE == len_q;
  assign out_last = out_valid && beats == len_q - ONE;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = length == '0 ? DRAIN : RUN;
    else if (state == RUN && last_issue) state_nx = DRAIN;
    else if (state == DRAIN && (len_q == '0 || last_pop)) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      inflight <= 1'b0;
      len_q <= '0;
      issued <= '0;
      beats <= '0;
      mem_a <= '0;
    end else begin
      state <= state_nx;
      done <= state == DRAIN && state_nx == IDLE;
      inflight <= issue;
      if (accept) begin
        len_q <= length;
        mem_a <= base_addr;
        issued <= '0;
        beats <= '0;
      end else begin
        if (issue) begin
          issued <= issued + ONE;
          mem_a <= mem_a == ADDR_WIDTH'(ADDR_SIZE - 1) ? '0 : mem_a + ADDR_WIDTH'(1);
        end
        if (pop) beats <= beats + ONE;
      end
    end
  skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight),
    .din(mem_q),
    .pop(pop),
    .dout(out_data),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized and directed bursts checked against an address/data model of the RAM stream
module tb_ram_stream_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [9:0] base_addr = '0;
  logic [10:0] length = '0;
  logic busy, done, mem_we, out_valid, out_last;
  logic [9:0] mem_a;
  logic [15:0] mem_d, mem_q, out_data;
  logic [15:0] ram [1024];
  int checks = 0, failures = 0;
  ram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_q <= ram[mem_a];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic pick(input int mode, input int c);
    logic [5:0] pat = 6'b101001;
    if (mode == 1) return $urandom_range(0, 3) != 0;
    if (mode == 2) return c < 3 ? 1'b1 : pat[(c - 3) % 6];
    return 1'b1;
  endfunction
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_mem_a"}, mem_a, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask
  // mode: 0 ready high, 1 random ready, 2 fixed 1,0,0,1,0,1 pattern; inject: restart attempt mid-burst
  task automatic burst(input int b, input int l, input int mode, input bit inject, input int abort_at);
    int beats = 0, cyc = 1, first = -1, ahead;
    bit done_seen = 0, stalled = 0;
    logic [15:0] prev_d = '0;
    @(negedge clk);
    base_addr = 10'(b);
    length = 11'(l);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      out_ready = pick(mode, cyc);
      if (inject && cyc == 2) begin
        base_addr = 10'($urandom);
        length = 11'd10;
        start = 1'b1;
      end else start = 1'b0;
      if (abort_at >= 0 && beats == abort_at && out_valid) return;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
      end
      if (busy && l < 1024) begin
        ahead = ((int'(mem_a) - b) & 1023) - beats;
        chk("ahead", ahead >= 0 && ahead <= 2, 1);
      end
      if (done) begin
        done_seen = 1;
        chk("done_beats", beats, l);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        if (mode == 0) chk("done_lat", cyc, l == 0 ? 2 : l + 3);
      end
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        chk("data", out_data, ram[(b + beats) % 1024]);
        chk("last", out_last, beats == l - 1);
        beats++;
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done_seen) chk("timeout", 0, 1);
    chk("beats", beats, l);
    chk("done_pulse", done, 0);
    if (l == 0) chk("zero_valid", first, -1);
    else if (mode == 0) chk("first_lat", first, 3);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    #1;
    check_idle_outputs("reset");
    chk("mem_we", mem_we, 0);
    chk("mem_d", mem_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ram[5] = 16'hA;
    ram[6] = 16'hB;
    ram[7] = 16'hC;
    ram[8] = 16'hD;
    burst(5, 4, 0, 0, -1);
    burst(1022, 4, 0, 0, -1);
    burst(100, 3, 2, 0, -1);
    burst(200, 0, 0, 0, -1);
    burst(300, 6, 0, 1, -1);
    burst(1020, 1, 0, 0, -1);
    burst(40, 8, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_stale", out_valid, 0);
    burst(600, 8, 0, 0, -1);
    for (int k = 0; k < 12; k++) burst(int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)), k % 3, k % 4 == 3, -1);
    burst(int'($urandom_range(0, 1023)), 1024, 0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
